data_memory: RTL and testbench

- Word-addressed RAM that responds to the CPU's memory bus (mem_we/mem_addr/mem_data out of the CPU, mem_in back into it).
- After reset it zero-fills itself, then accepts a program image over a valid/ready loader stream.
- When loading finishes it asserts cpu_run, which releases the CPU, and serves reads and writes with 1-cycle read latency.
- Sits beside the CPU in the sim top level; all CPU-facing port names match the CPU's names so the two connect by name.

---
 rtl/data_memory_pkg.sv | 17 +
 rtl/data_memory_array.sv | 43 ++++
 rtl/data_memory.sv | 139 +++++++++++++
 tb/tb_data_memory.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg
// Shared definitions for the data_memory block: the controller state encoding
// and the word-depth derivation used by the RAM and its controller.
package data_memory_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Number of words addressable with addr_width address bits.
    function automatic int mem_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// data_memory_array
// Single-port word RAM with a registered read port.
//
// Optional feature macro: DATA_MEMORY_WRITE_FIRST_EN
//   undefined : read-during-write returns the old word (read-first)
//   defined   : read-during-write returns the word being written (write-first)
//
// Ports:
//   clk    in   clock
//   we     in   write enable for addr
//   addr   in   shared read/write word address
//   wdata  in   write data
//   rdata  out  read data, registered (valid the cycle after addr)
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = mem_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
`ifdef DATA_MEMORY_WRITE_FIRST_EN
        // Only one port, so a write always targets the address being read.
        rdata <= we ? wdata : mem[addr];
`else
        rdata <= mem[addr];
`endif
    end

endmodule

// File: rtl/data_memory.sv
// data_memory
// Word-addressed RAM for the CPU. After reset it zero-fills itself (CLEAR),
// accepts a program image over a valid/ready stream (LOAD), then releases the
// CPU via cpu_run and serves reads/writes with one-cycle read latency (RUN).
//
// Optional feature macro: DATA_MEMORY_WRITE_FIRST_EN (write-first bypass on a
// same-cycle read/write of one address in RUN; default is read-first).
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   mem_we       in   CPU write enable
//   mem_addr     in   CPU word address
//   mem_data     in   CPU write data
//   mem_in       out  registered read data to the CPU (0 outside RUN)
//   ld_valid     in   loader word valid
//   ld_data      in   loader word
//   ld_last      in   loader marks the final word
//   ld_ready     out  loader may transfer (high in LOAD)
//   cpu_run      out  high in RUN, one cycle behind the state; CPU reset_n
//   ld_count     out  words accepted from the loader, saturating at DEPTH
//   ld_overflow  out  sticky: image was longer than DEPTH words
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] mem_in,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  cpu_run,
    output logic [ADDR_WIDTH:0]   ld_count,
    output logic                  ld_overflow
);

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX   = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  accept;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign ld_ready = (state == LOAD);

    // Read data is registered in the array; gating with the registered
    // cpu_run keeps mem_in at 0 through reset, CLEAR, LOAD and the first RUN
    // cycle, whose read only becomes visible one cycle later anyway.
    assign mem_in = cpu_run ? arr_rdata : '0;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        arr_we     = 1'b0;
        arr_addr   = ptr;
        arr_wdata  = '0;
        case (state)
            CLEAR: begin
                arr_we = 1'b1;
                if (ptr == PTR_MAX) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                accept    = ld_valid;
                arr_we    = ld_valid;
                arr_wdata = ld_data;
                // The final word, or a word landing in the top slot, ends the
                // load; anything after a top-slot word is an overflow.
                if (ld_valid && (ld_last || ptr == PTR_MAX)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                arr_we    = mem_we;
                arr_addr  = mem_addr;
                arr_wdata = mem_data;
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
        // Reset takes priority over any write or transfer in the same cycle.
        if (rst) begin
            arr_we = 1'b0;
            accept = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            ptr         <= '0;
            ld_count    <= '0;
            ld_overflow <= 1'b0;
            cpu_run     <= 1'b0;
        end else begin
            state   <= next_state;
            cpu_run <= (state == RUN);
            // The pointer wraps from PTR_MAX to 0, which leaves it at 0 on
            // entry to LOAD.
            if (state == CLEAR || accept) begin
                ptr <= ptr + PTR_ONE;
            end
            if (accept && ld_count != COUNT_MAX) begin
                ld_count <= ld_count + COUNT_ONE;
            end
            if (accept && ptr == PTR_MAX && !ld_last) begin
                ld_overflow <= 1'b1;
            end
        end
    end

    data_memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
// Randomized bench for data_memory with a word-array reference model of the
// memory image, loader count and overflow flag.
module tb_data_memory;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] mem_in;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          cpu_run;
    logic [AW:0]   ld_count;
    logic          ld_overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] model_mem [DEPTH];
    int            model_ptr;
    int            model_count;
    logic          model_ovf;

    data_memory #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_in      (mem_in),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .cpu_run     (cpu_run),
        .ld_count    (ld_count),
        .ld_overflow (ld_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_ptr   = 0;
        model_count = 0;
        model_ovf   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check("rst_cpu_run", cpu_run, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_mem_in", mem_in, 0);
        check("rst_ld_count", ld_count, 0);
        check("rst_ld_overflow", ld_overflow, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ld_ready && n < 200) begin
            step();
            n++;
        end
        check("ld_ready_wait", ld_ready, 1);
    endtask

    // Offer one loader word (after optional idle gap); acc reports whether the
    // interface was ready at the transfer edge.
    task automatic send_word(input logic [DW-1:0] d, input logic last, input bit gaps,
                             output bit acc);
        if (gaps) repeat ($urandom_range(0, 3)) step();
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        acc      = ld_ready;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (acc) begin
            model_mem[model_ptr] = d;
            if (model_ptr == DEPTH - 1 && !last) model_ovf = 1'b1;
            model_ptr++;
            if (model_count < DEPTH) model_count++;
        end
    endtask

    // One CPU bus cycle in RUN; mem_in after the edge holds this cycle's read.
    task automatic run_cycle(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] exp;
        mem_we   = we;
        mem_addr = a;
        mem_data = d;
        step();
`ifdef DATA_MEMORY_WRITE_FIRST_EN
        exp = we ? d : model_mem[a];
`else
        exp = model_mem[a];
`endif
        if (we) model_mem[a] = d;
        mem_we = 1'b0;
        check($sformatf("rd_addr%0d", a), mem_in, exp);
    endtask

    task automatic backdoor_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s_%0d", tag, i), dut.u_array.mem[i], 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [DW-1:0] w;

        step();
        do_reset();

        // CLEAR lasts exactly DEPTH cycles; bus and loader traffic is ignored.
        for (int i = 1; i <= DEPTH; i++) begin
            if (i < 60) begin
                ld_valid = 1'($urandom_range(0, 1));
                ld_data  = DW'($urandom) | 16'h1;
                ld_last  = 1'($urandom_range(0, 1));
                mem_we   = 1'b1;
                mem_addr = AW'($urandom);
                mem_data = DW'($urandom) | 16'h1;
            end else begin
                ld_valid = 1'b0;
                ld_last  = 1'b0;
                mem_we   = 1'b0;
            end
            step();
            check($sformatf("clear_ld_ready_c%0d", i), ld_ready, (i == DEPTH) ? 1 : 0);
            check($sformatf("clear_cpu_run_c%0d", i), cpu_run, 0);
        end
        backdoor_zero("clear_zero");

        // Short image with gaps; ld_last on the third word.
        send_word(16'h1234, 1'b0, 1'b1, acc);
        send_word(16'hABCD, 1'b0, 1'b1, acc);
        repeat (3) step();
        check("stall_ld_ready", ld_ready, 1);
        send_word(16'h0F0F, 1'b1, 1'b1, acc);
        check("load3_ld_count", ld_count, 3);
        check("load3_ld_ready", ld_ready, 0);
        check("load3_cpu_run_early", cpu_run, 0);
        step();
        check("load3_cpu_run", cpu_run, 1);
        check("load3_ovf", ld_overflow, 0);
        for (int a = 0; a < 4; a++) run_cycle(1'b0, AW'(a), '0);

        // Write then read back.
        run_cycle(1'b1, 6'd5, 16'h00AA);
        run_cycle(1'b0, 6'd5, '0);

        // Same-cycle write/read of one address.
        run_cycle(1'b1, 6'd7, 16'h0001);
        run_cycle(1'b1, 6'd7, 16'h0002);
        run_cycle(1'b0, 6'd7, '0);

        // Random CPU traffic.
        for (int i = 0; i < 40; i++) begin
            run_cycle(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
        end

        // Reset from RUN, then an over-long image.
        do_reset();
        wait_ready();
        for (int i = 0; i < DEPTH; i++) begin
            send_word(DW'($urandom) | 16'h1, 1'b0, 1'b0, acc);
        end
        check("ovf_flag", ld_overflow, 1);
        check("ovf_ld_count", ld_count, DEPTH);
        check("ovf_model_flag", ld_overflow, 32'(model_ovf));
        check("ovf_ld_ready", ld_ready, 0);
        send_word(16'hDEAD, 1'b0, 1'b0, acc);
        check("ovf_word65_accepted", 32'(acc), 0);
        check("ovf_cpu_run", cpu_run, 1);
        check("ovf_ld_count_hold", ld_count, 32'(model_count));
        for (int a = 0; a < DEPTH; a++) run_cycle(1'b0, AW'(a), '0);

        // Reset during LOAD after two words.
        do_reset();
        wait_ready();
        send_word(16'h1111, 1'b0, 1'b1, acc);
        send_word(16'h2222, 1'b0, 1'b1, acc);
        check("pre_rst_ld_count", ld_count, 2);
        rst      = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 16'hBEEF;
        ld_last  = 1'b1;
        step();
        rst      = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        model_reset();
        check("midload_rst_ld_count", ld_count, 0);
        check("midload_rst_ld_ready", ld_ready, 0);
        check("midload_rst_cpu_run", cpu_run, 0);
        wait_ready();
        backdoor_zero("rezero");
        w = DW'($urandom) | 16'h1;
        send_word(w, 1'b1, 1'b1, acc);
        check("reload_ld_count", ld_count, 1);
        step();
        check("reload_cpu_run", cpu_run, 1);
        for (int a = 0; a < 4; a++) run_cycle(1'b0, AW'(a), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
